// File: rtl/vend_payout_ctrl_if.sv
// ============================================================================
// Module      : vend_payout_ctrl_if
// Description : Request/actuator bundle between the vending FSM and the
//               payout controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vend_payout_ctrl_if;
    logic       dispense;
    logic [1:0] change;
    logic       motor_done;
    logic       fault_clr;
    logic       motor_on;
    logic       eject_5;
    logic       busy;
    logic       fault;
    logic       req_lost;

    modport master (
        output dispense, change, motor_done, fault_clr,
        input  motor_on, eject_5, busy, fault, req_lost
    );

    modport slave (
        input  dispense, change, motor_done, fault_clr,
        output motor_on, eject_5, busy, fault, req_lost
    );
endinterface

`default_nettype wire

// File: rtl/vend_payout_ctrl.sv
// ============================================================================
// Module      : vend_payout_ctrl
// Description : Queues vend/change pulses and drives the product motor and
//               the 5-rupee hopper with motor timeout and fault handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_payout_ctrl #(
    parameter int MOTOR_TIMEOUT = 1000,
    parameter int COIN_PULSE    = 4,
    parameter int COIN_GAP      = 4,
    parameter int MAX_PENDING   = 3
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    vend_payout_ctrl_if.slave  bus
);

    localparam int VP_W   = $clog2(MAX_PENDING + 1);
    localparam int TMR_W  = $clog2(MOTOR_TIMEOUT + 1);
    localparam int PH_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_vend      = 3'd1;
    localparam logic [2:0] c_pay_pulse = 3'd2;
    localparam logic [2:0] c_pay_gap   = 3'd3;
    localparam logic [2:0] c_fault     = 3'd4;

    localparam logic [TMR_W-1:0] c_tmr_last   = TMR_W'(MOTOR_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  c_pulse_last = PH_W'(COIN_PULSE - 1);
    localparam logic [PH_W-1:0]  c_gap_last   = PH_W'(COIN_GAP - 1);
    localparam logic [VP_W-1:0]  c_vend_max   = VP_W'(MAX_PENDING);

    logic [2:0]       state_q, state_d;
    logic [VP_W-1:0]  vend_pend_q, vend_pend_d;
    logic [3:0]       coin_pend_q, coin_pend_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             req_lost_q, req_lost_d;
    logic             motor_on_q, motor_on_d;
    logic             eject_5_q, eject_5_d;
    logic             fault_q, fault_d;

    logic             dispatch;
    logic             vend_dec;
    logic             coin_dec;
    logic             drop;
    logic [1:0]       coin_add;
    logic [VP_W:0]    vend_sum;
    logic [4:0]       coin_sum;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= c_idle;
            vend_pend_q <= '0;
            coin_pend_q <= '0;
            tmr_q       <= '0;
            phase_q     <= '0;
            req_lost_q  <= 1'b0;
            motor_on_q  <= 1'b0;
            eject_5_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vend_pend_q <= vend_pend_d;
            coin_pend_q <= coin_pend_d;
            tmr_q       <= tmr_d;
            phase_q     <= phase_d;
            req_lost_q  <= req_lost_d;
            motor_on_q  <= motor_on_d;
            eject_5_q   <= eject_5_d;
            fault_q     <= fault_d;
        end
    end

    // Next state, dispatch and pending-count update
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        phase_d  = phase_q;
        dispatch = 1'b0;
        vend_dec = 1'b0;
        coin_dec = 1'b0;

        case (state_q)
            c_idle: dispatch = 1'b1;
            c_vend: begin
                if (bus.motor_done) begin
                    dispatch = 1'b1;
                end else if (tmr_q == c_tmr_last) begin
                    state_d = c_fault;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            c_pay_pulse: begin
                if (phase_q == c_pulse_last) begin
                    state_d = c_pay_gap;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            c_pay_gap: begin
                if (phase_q == c_gap_last) begin
                    dispatch = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            c_fault: begin
                if (bus.fault_clr) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase

        // Decision sees the counts before this cycle's new requests
        if (dispatch) begin
            if (vend_pend_q != '0) begin
                state_d  = c_vend;
                vend_dec = 1'b1;
                tmr_d    = '0;
            end else if (coin_pend_q != 4'd0) begin
                state_d  = c_pay_pulse;
                coin_dec = 1'b1;
                phase_d  = '0;
            end else begin
                state_d  = c_idle;
            end
        end

        coin_add = (bus.change == 2'b11) ? 2'b00 : bus.change;
        vend_sum = {1'b0, vend_pend_q} + {{VP_W{1'b0}}, bus.dispense}
                 - {{VP_W{1'b0}}, vend_dec};
        coin_sum = {1'b0, coin_pend_q} + {3'b000, coin_add} - {4'b0000, coin_dec};

        drop = 1'b0;
        if (vend_sum > {1'b0, c_vend_max}) begin
            vend_pend_d = c_vend_max;
            drop        = 1'b1;
        end else begin
            vend_pend_d = vend_sum[VP_W-1:0];
        end
        if (coin_sum > 5'd15) begin
            coin_pend_d = 4'd15;
            drop        = 1'b1;
        end else begin
            coin_pend_d = coin_sum[3:0];
        end

        // A fresh drop outranks a simultaneous clear
        if (drop) begin
            req_lost_d = 1'b1;
        end else if (bus.fault_clr) begin
            req_lost_d = 1'b0;
        end else begin
            req_lost_d = req_lost_q;
        end
    end

    always_comb begin
        motor_on_d = (state_d == c_vend);
        eject_5_d  = (state_d == c_pay_pulse);
        fault_d    = (state_d == c_fault);
    end

    assign bus.motor_on = motor_on_q;
    assign bus.eject_5  = eject_5_q;
    assign bus.fault    = fault_q;
    assign bus.req_lost = req_lost_q;
    assign bus.busy     = (state_q != c_idle) || (vend_pend_q != '0)
                       || (coin_pend_q != 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_vend_payout_ctrl.sv
// ============================================================================
// Module      : tb_vend_payout_ctrl
// Description : Self-checking bench: vector table, corner-case sequences and
//               randomized traffic against a job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_payout_ctrl;

    localparam int TMO = 8;
    localparam int CP  = 4;
    localparam int CG  = 4;
    localparam int MP  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vend_payout_ctrl_if bus();

    vend_payout_ctrl #(
        .MOTOR_TIMEOUT (TMO),
        .COIN_PULSE    (CP),
        .COIN_GAP      (CG),
        .MAX_PENDING   (MP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      grp;
        logic       d;
        logic [1:0] ch;
        logic       md;
        logic       fc;
        logic [4:0] exp_o;   // {motor_on, eject_5, busy, fault, req_lost}
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string g, logic d, logic [1:0] ch, logic md, logic fc,
                                logic mo, logic ej, logic bz, logic ft, logic rl);
        vec_t v;
        v.grp = g; v.d = d; v.ch = ch; v.md = md; v.fc = fc;
        v.exp_o = {mo, ej, bz, ft, rl};
        tbl.push_back(v);
    endfunction

    function automatic logic [4:0] outs();
        return {bus.motor_on, bus.eject_5, bus.busy, bus.fault, bus.req_lost};
    endfunction

    task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {mo,ej,busy,flt,lost}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic [1:0] ch, input logic md, input logic fc);
        bus.dispense   = d;
        bus.change     = ch;
        bus.motor_done = md;
        bus.fault_clr  = fc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 2'b00, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check5("reset", outs(), 5'b00000);
        #3 reset_n = 1'b1;
    endtask

    // Reference model: pending totals plus the job currently being served
    int m_vp, m_cp, m_age, m_t;
    bit m_vend, m_coin, m_flt, m_lost;

    function automatic void model_reset();
        m_vp = 0; m_cp = 0; m_age = 0; m_t = 0;
        m_vend = 0; m_coin = 0; m_flt = 0; m_lost = 0;
    endfunction

    function automatic void model_step(bit d, bit [1:0] ch, bit md, bit fc);
        bit disp;
        int add_units;
        disp = 0;
        if (m_flt) begin
            if (fc) m_flt = 0;
        end else if (m_vend) begin
            if (md) disp = 1;
            else if (m_age == TMO - 1) begin m_vend = 0; m_flt = 1; end
            else m_age++;
        end else if (m_coin) begin
            m_t++;
            if (m_t == CP + CG) disp = 1;
        end else begin
            disp = 1;
        end
        if (disp) begin
            m_vend = 0; m_coin = 0;
            if (m_vp > 0) begin m_vp--; m_vend = 1; m_age = 0; end
            else if (m_cp > 0) begin m_cp--; m_coin = 1; m_t = 0; end
        end
        if (fc) m_lost = 0;
        m_vp += d;
        if (m_vp > MP) begin m_vp = MP; m_lost = 1; end
        add_units = (ch == 2'd1) ? 1 : (ch == 2'd2) ? 2 : 0;
        m_cp += add_units;
        if (m_cp > 15) begin m_cp = 15; m_lost = 1; end
    endfunction

    function automatic logic [4:0] model_outs();
        logic bz;
        bz = m_vend || m_coin || m_flt || (m_vp > 0) || (m_cp > 0);
        return {m_vend, m_coin && (m_t < CP), bz, m_flt, m_lost};
    endfunction

    initial begin
        int vends, pulses;
        bit prev_ej, done;
        bit r_d, r_md, r_fc;
        bit [1:0] r_ch;

        drive(0, 2'b00, 0, 0);

        // Single vend, motor_done 5 cycles after motor_on rises
        add("vend", 1, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) add("vend_on", 0, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add("vend_done", 0, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        // Rs10 change: two pulses, no idle bubble
        add("chg10", 0, 2'd2, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CP; i++) add("chg10_hi", 0, 2'd0, 0, 0, 0, 1, 1, 0, 0);
            for (int i = 0; i < CG; i++) add("chg10_lo", 0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        end
        add("chg10_idle", 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        // Code 11 is ignored
        add("chg11", 0, 2'd3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("chg11_q", 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        // Vend and change together: vend first
        add("both", 1, 2'd1, 0, 0, 0, 0, 1, 0, 0);
        add("both_mo", 0, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add("both_done", 0, 2'd0, 1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < CP - 1; i++) add("both_hi", 0, 2'd0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < CG; i++) add("both_lo", 0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        add("both_idle", 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        // Motor timeout, change during FAULT, fault_clr
        add("tmo", 1, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TMO; i++) add("tmo_on", 0, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        add("tmo_fault", 0, 2'd0, 0, 0, 0, 0, 1, 1, 0);
        add("fault_chg", 0, 2'd1, 0, 0, 0, 0, 1, 1, 0);
        add("fault_clr", 0, 2'd0, 0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < CP; i++) add("post_hi", 0, 2'd0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < CG; i++) add("post_lo", 0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        add("post_idle", 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].ch, tbl[i].md, tbl[i].fc);
            tick();
            check5($sformatf("%s[%0d]", tbl[i].grp, i), outs(), tbl[i].exp_o);
        end
        drive(0, 2'b00, 0, 0);

        // Saturation with the motor stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b00, 0, 0);
            tick();
        end
        drive(0, 2'b00, 0, 0);
        checkn("vend_sat_lost", bus.req_lost, 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, 2'b01, 0, 0);
            tick();
        end
        drive(0, 2'b00, 0, 0);
        checkn("stall_fault", bus.fault, 1);
        drive(0, 2'b00, 0, 1);
        tick();
        drive(0, 2'b00, 1, 0);
        checkn("clr_lost", bus.req_lost, 0);
        checkn("clr_fault", bus.fault, 0);
        vends = 0; pulses = 0; prev_ej = 0; done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            tick();
            if (bus.motor_on) vends++;
            if (bus.eject_5 && !prev_ej) pulses++;
            prev_ej = bus.eject_5;
            if (!bus.busy) done = 1;
        end
        drive(0, 2'b00, 0, 0);
        checkn("drain_bound", done, 1);
        checkn("sat_vends", vends, MP);
        checkn("sat_pulses", pulses, 15);

        // Reset during the second cycle of an eject pulse
        do_reset();
        drive(0, 2'b01, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0);
        tick();
        tick();
        checkn("pre_rst_ej", bus.eject_5, 1);
        #2 reset_n = 1'b0;
        #1;
        check5("async_rst", outs(), 5'b00000);
        repeat (2) @(posedge clk);
        #4 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check5($sformatf("post_rst[%0d]", i), outs(), 5'b00000);
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            r_d  = ($urandom % 6) == 0;
            r_ch = (($urandom % 5) == 0) ? 2'($urandom % 4) : 2'b00;
            r_md = ($urandom % 5) == 0;
            r_fc = ($urandom % 12) == 0;
            drive(r_d, r_ch, r_md, r_fc);
            tick();
            model_step(r_d, r_ch, r_md, r_fc);
            check5($sformatf("rand[%0d]", c), outs(), model_outs());
        end
        drive(0, 2'b00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
